// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/writeback with a halt state.
// Define INSTR_COUNTER_EN to enable the retired-instruction counter; otherwise instr_count is tied to 0.
module control_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic [1:0]       compcode,
   input  logic             mem_ready,
   output logic             irw,
   output logic             pcw,
   output logic [1:0]       pc_src,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic [1:0]       alu_op,
   output logic             branch_en,
   output logic             illegal,
   output logic             halted,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   // state  | meaning
   // FETCH  | read instruction, wait for mem_ready, latch IR and PC+1
   // DECODE | route by opcode; jump, halt and illegal opcodes finish here
   // EXEC   | ALU operation or branch resolution
   // MEM    | load/store data access, waits for mem_ready
   // WB     | register file write
   // HALT   | stopped until reset
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic       irw_c, pcw_c, mem_write_c, reg_write_c;
   logic       retire;

   always_ff @(posedge CLK) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      irw_c       = 1'b0;
      pcw_c       = 1'b0;
      pc_src      = 2'd0;
      mem_read    = 1'b0;
      mem_write_c = 1'b0;
      reg_write_c = 1'b0;
      alu_op      = 2'd0;
      branch_en   = 1'b0;
      illegal     = 1'b0;
      halted      = 1'b0;
      retire      = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               irw_c   = 1'b1;
               pcw_c   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (opcode <= 4'd6) begin
               state_d = EXEC;
            end else if (opcode == 4'd7) begin
               pcw_c   = 1'b1;
               pc_src  = 2'd2;
               retire  = 1'b1;
               state_d = FETCH;
            end else if (opcode == 4'd15) begin
               retire  = 1'b1;
               state_d = HALT;
            end else begin
               illegal = 1'b1;
               state_d = FETCH;
            end
         end
         EXEC: begin
            alu_op = opcode[1:0];
            if (opcode <= 4'd3) begin
               state_d = WB;
            end else if (opcode == 4'd4 || opcode == 4'd5) begin
               state_d = MEM;
            end else if (opcode == 4'd6) begin
               branch_en = 1'b1;
               pcw_c     = 1'b1;
               pc_src    = 2'd1;
               retire    = 1'b1;
               state_d   = FETCH;
            end else begin
               state_d = FETCH;
            end
         end
         MEM: begin
            if (opcode == 4'd4) begin
               mem_read = 1'b1;
               if (mem_ready) state_d = WB;
            end else if (opcode == 4'd5) begin
               mem_write_c = 1'b1;
               if (mem_ready) begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end
            end else begin
               state_d = FETCH;
            end
         end
         WB: begin
            reg_write_c = 1'b1;
            retire      = 1'b1;
            state_d     = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // Write strobes are suppressed while reset is held so nothing commits mid-reset.
   assign irw       = irw_c       & ~reset;
   assign pcw       = pcw_c       & ~reset;
   assign mem_write = mem_write_c & ~reset;
   assign reg_write = reg_write_c & ~reset;
   assign state     = state_q;

   // compcode feeds the datapath comparator; the sequencer only raises branch_en.
   logic unused_compcode;
   assign unused_compcode = ^compcode;

`ifdef INSTR_COUNTER_EN
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge CLK) begin
      if (reset)       count_q <= '0;
      else if (retire) count_q <= count_q + CNT_W'(1);
   end

   assign instr_count = count_q;
`else
   logic unused_retire;
   assign unused_retire = retire;
   assign instr_count   = '0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboarded bench for control_fsm: a per-instruction model predicts strobe totals,
// latency, state path and retire count; a negedge monitor segments DUT activity and compares.
module tb_control_fsm;
   localparam int TB_CW = 5;

   logic             CLK = 1'b0;
   logic             reset;
   logic [3:0]       opcode;
   logic [1:0]       compcode;
   logic             mem_ready;
   logic             irw, pcw, mem_read, mem_write, reg_write, branch_en, illegal, halted;
   logic [1:0]       pc_src, alu_op;
   logic [2:0]       state;
   logic [TB_CW-1:0] instr_count;

   control_fsm #(.CNT_W(TB_CW)) dut (
      .CLK(CLK), .reset(reset), .opcode(opcode), .compcode(compcode), .mem_ready(mem_ready),
      .irw(irw), .pcw(pcw), .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .alu_op(alu_op), .branch_en(branch_en), .illegal(illegal),
      .halted(halted), .state(state), .instr_count(instr_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int cycles; int irw_n; int pcw_n; int pcsrc_sum; int rd_n; int wr_n;
      int rw_n; int br_n; int ill_n; int alu; int path; int cnt;
   } rec_t;

   rec_t exp_q[$];
   rec_t acc;
   int   n_checks = 0, n_fail = 0, pushed = 0, popped = 0;
   logic [TB_CW-1:0] model_cnt = '0;
   bit   started = 0;
   logic [2:0] prev_st = 3'd0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int push_state(input int path, input int st);
      return (path << 3) | st;
   endfunction

   // Reference: strobe totals and visited states per instruction class.
   task automatic model_push(input int op, input int fw, input int mw);
      rec_t e;
      bit   ret;
      e = '{default: 0};
      e.cycles = fw + 1; e.rd_n = fw + 1; e.irw_n = 1; e.pcw_n = 1;
      e.path = push_state(push_state(0, 0), 1);
      e.cycles += 1;
      ret = 1;
      if (op <= 6) begin
         e.path = push_state(e.path, 2);
         e.cycles += 1;
         e.alu = op % 4;
         if (op <= 3) begin
            e.path = push_state(e.path, 4); e.cycles += 1; e.rw_n = 1;
         end else if (op == 4) begin
            e.path = push_state(push_state(e.path, 3), 4);
            e.cycles += mw + 2; e.rd_n += mw + 1; e.rw_n = 1;
         end else if (op == 5) begin
            e.path = push_state(e.path, 3);
            e.cycles += mw + 1; e.wr_n = mw + 1;
         end else begin
            e.br_n = 1; e.pcw_n = 2; e.pcsrc_sum = 1;
         end
      end else if (op == 7) begin
         e.pcw_n = 2; e.pcsrc_sum = 2;
      end else if (op != 15) begin
         e.ill_n = 1; ret = 0;
      end
`ifdef INSTR_COUNTER_EN
      if (ret) model_cnt = model_cnt + 1'b1;
      e.cnt = int'(model_cnt);
`else
      e.cnt = 0;
`endif
      exp_q.push_back(e);
      pushed++;
   endtask

   always @(negedge CLK) begin
      if (reset) begin
         started = 0; acc = '{default: 0}; prev_st = 3'd0;
      end else begin
         if (started && ((state == 3'd0 && prev_st != 3'd0) || (state == 3'd5 && prev_st != 3'd5))) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_instr", 1, 0);
            end else begin
               rec_t e;
               e = exp_q.pop_front();
               popped++;
               chk("latency",    acc.cycles,    e.cycles);
               chk("irw_cnt",    acc.irw_n,     e.irw_n);
               chk("pcw_cnt",    acc.pcw_n,     e.pcw_n);
               chk("pc_src_sum", acc.pcsrc_sum, e.pcsrc_sum);
               chk("mem_read",   acc.rd_n,      e.rd_n);
               chk("mem_write",  acc.wr_n,      e.wr_n);
               chk("reg_write",  acc.rw_n,      e.rw_n);
               chk("branch_en",  acc.br_n,      e.br_n);
               chk("illegal",    acc.ill_n,     e.ill_n);
               chk("alu_op",     acc.alu,       e.alu);
               chk("state_path", acc.path,      e.path);
               chk("instr_cnt",  int'(instr_count), e.cnt);
            end
            started = 0; acc = '{default: 0};
         end
         if (state != 3'd5) begin
            if (acc.cycles == 0) acc.path = int'(state);
            else if (state != prev_st) acc.path = push_state(acc.path, int'(state));
            acc.cycles++;
            if (irw) acc.irw_n++;
            if (pcw) begin acc.pcw_n++; acc.pcsrc_sum += int'(pc_src); end
            if (mem_read)  acc.rd_n++;
            if (mem_write) acc.wr_n++;
            if (reg_write) acc.rw_n++;
            if (branch_en) acc.br_n++;
            if (illegal)   acc.ill_n++;
            if (state == 3'd2) acc.alu = int'(alu_op);
            started = 1;
         end
         prev_st = state;
      end
   end

   // Entered and left at posedge+1 with state stable; mem_ready reacts to the wait counts.
   task automatic run_instr(input int op, input int cc, input int fw, input int mw);
      int fc = 0, mc = 0;
      bit left = 0, done = 0;
      model_push(op, fw, mw);
      opcode = 4'(op); compcode = 2'(cc);
      for (int c = 0; c < 200 && !done; c++) begin
         case (state)
            3'd0: if (left) done = 1;
                  else begin mem_ready = (fc >= fw); fc++; end
            3'd3: begin left = 1; mem_ready = (mc >= mw); mc++; end
            3'd5: done = 1;
            default: begin left = 1; mem_ready = 1'($urandom_range(0, 1)); end
         endcase
         if (!done) begin @(posedge CLK); #1; end
      end
      chk("instr_done", int'(done), 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
      model_cnt = '0;
   endtask

   initial begin
      reset = 1'b1; opcode = 4'd0; compcode = 2'd0; mem_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_state",   int'(state), 0);
      chk("rst_halted",  int'(halted), 0);
      chk("rst_illegal", int'(illegal), 0);
      chk("rst_pc_src",  int'(pc_src), 0);
      chk("rst_irw",     int'(irw), 0);
      chk("rst_pcw",     int'(pcw), 0);
      chk("rst_count",   int'(instr_count), 0);
      reset = 1'b0;

      run_instr(0, 0, 0, 0);
      run_instr(4, 0, 0, 3);
      run_instr(6, 2, 0, 0);
      run_instr(9, 0, 0, 0);
      run_instr(7, 0, 1, 0);
      run_instr(5, 1, 2, 1);
      run_instr(3, 0, 0, 0);
      for (int i = 0; i < 40; i++) run_instr(7, 0, 0, 0);
      for (int i = 0; i < 150; i++)
         run_instr($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));

      // Reset during a stalled store: strobes gated, state and counter cleared.
      opcode = 4'd5; compcode = 2'd0;
      for (int c = 0; c < 20 && state != 3'd3; c++) begin
         mem_ready = 1'b1;
         @(posedge CLK); #1;
      end
      chk("reach_mem", int'(state), 3);
      mem_ready = 1'b0;
      chk("mem_wr_pre", int'(mem_write), 1);
      reset = 1'b1; #1;
      chk("rst_mem_write", int'(mem_write), 0);
      chk("rst_reg_write", int'(reg_write), 0);
      @(posedge CLK); #1;
      chk("midmem_state", int'(state), 0);
      chk("midmem_count", int'(instr_count), 0);
      reset = 1'b0; model_cnt = '0;

      run_instr(1, 0, 0, 0);
      run_instr(15, 0, 0, 0);
      @(negedge CLK);
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'($urandom_range(0, 1)); opcode = 4'($urandom_range(0, 15));
         @(posedge CLK); #1;
         chk("halt_state",   int'(state), 5);
         chk("halt_flag",    int'(halted), 1);
         chk("halt_strobes", int'({irw, pcw, mem_read, mem_write, reg_write, branch_en, illegal}), 0);
      end
      chk("halt_count", int'(instr_count), int'(exp_q.size() == 0 ? model_cnt : '0));
      do_reset();
      chk("post_halt_state",  int'(state), 0);
      chk("post_halt_flag",   int'(halted), 0);
      chk("post_halt_count",  int'(instr_count), 0);

      run_instr(2, 0, 0, 0);
      repeat (2) @(posedge CLK);
      chk("queue_empty", exp_q.size(), 0);
      chk("popped", popped, pushed);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of retired-instruction counter.
REQ-002 SHALL have port CLK  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  4  opcode from instruction register, valid from DECODE onward.
REQ-005 SHALL have port compcode  input  2  branch condition code from instruction register.
REQ-006 SHALL have port mem_ready  input  1  memory handshake, access completes in cycle it is high.
REQ-007 SHALL have port irw  output  1  instruction register write enable.
REQ-008 SHALL have port pcw  output  1  PC write enable.
REQ-009 SHALL have port pc_src  output  2  0=PC+1, 1=branch target, 2=jump address.
REQ-010 SHALL have ports mem_read, mem_write, reg_write  output  1 each  datapath strobes.
REQ-011 SHALL have port alu_op  output  2  ALU operation, equals opcode[1:0] in EXEC.
REQ-012 SHALL have ports branch_en  output  1  (compare using compcode) and illegal  output  1  (illegal opcode pulse).
REQ-013 SHALL have ports halted  output  1,  state  output  3  (current state encoding), and instr_count  output  CNT_W.

Function
REQ-014 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6-7 return to FETCH next cycle.
REQ-015 SHALL in FETCH: mem_read=1; hold FETCH while mem_ready=0; when mem_ready=1 assert irw=1, pcw=1, pc_src=0 that cycle and go to DECODE.
REQ-016 SHALL in DECODE route: opcode 0-3 (ALU), 4 (LOAD), 5 (STORE), 6 (BRANCH) -> EXEC; 7 (JUMP) -> FETCH with pcw=1, pc_src=2; 15 -> HALT; 8-14 -> FETCH with illegal=1 for one cycle.
REQ-017 SHALL in EXEC: ALU -> WB; LOAD, STORE -> MEM; BRANCH -> FETCH with branch_en=1, pcw=1, pc_src=1.
REQ-018 SHALL in MEM: LOAD mem_read=1, STORE mem_write=1; hold while mem_ready=0; on mem_ready=1 LOAD -> WB, STORE -> FETCH.
REQ-019 SHALL in WB: reg_write=1 for exactly one cycle, then go to FETCH.
REQ-020 SHALL in HALT: halted=1, all strobes 0, remain until reset.
REQ-021 SHALL decode outputs combinationally from state, opcode and mem_ready; any strobe not listed for a state is 0.
REQ-022 SHALL latency: ALU 4 cycles, LOAD 5, STORE 4, BRANCH 3, JUMP 2, each with zero memory wait.
REQ-023 SHALL treat an instruction as retired on the cycle it returns to FETCH or enters HALT; illegal opcodes are not retired.

Reset
REQ-024 SHALL on reset=1 at a rising edge enter FETCH and clear instr_count regardless of current state, including mid-wait in MEM.
REQ-025 SHALL force irw, pcw, mem_write and reg_write to 0 while reset=1.
REQ-026 SHALL after reset present state=0, halted=0, illegal=0, pc_src=0.

Configuration
REQ-027 SHALL with INSTR_COUNTER_EN defined increment instr_count by 1 per retirement, wrapping from all-ones to 0.
REQ-028 SHALL without INSTR_COUNTER_EN keep port instr_count and drive it constant 0.

Verification
REQ-029 SHALL cover reset, mem_ready=1, opcode=0 -> states 0,1,2,4,0; irw in cycle 1; reg_write in cycle 4; instr_count=1.
REQ-030 SHALL cover opcode=4 with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_read high throughout, then WB.
REQ-031 SHALL cover opcode=6, compcode=2 -> branch_en=1, pcw=1, pc_src=1 in EXEC, back to FETCH.
REQ-032 SHALL cover opcode=9 -> illegal pulses 1 cycle in DECODE, instr_count unchanged.
REQ-033 SHALL cover opcode=15 -> halted=1 and state=5 held 20 cycles; reset then restores FETCH with instr_count=0.
REQ-034 SHALL cover counter at 0xFFFF plus one retirement -> 0x0000; without INSTR_COUNTER_EN it stays 0.
